// File: rtl/vram_write_bridge_pkg.sv
// gpu_pkg: shared types for the CPU-to-VRAM write path.
//   VRAM_ADDR_W / VRAM_DATA_W : widths of the graphics card write port
//   state_t                   : drain state of vram_write_bridge
//   vram_write_t              : one buffered write {addr, data}
package gpu_pkg;

  localparam int VRAM_ADDR_W = 16;
  localparam int VRAM_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_BLANK = 2'd1,
    ISSUE      = 2'd2
  } state_t;

  typedef struct packed {
    logic [VRAM_ADDR_W-1:0] addr;
    logic [VRAM_DATA_W-1:0] data;
  } vram_write_t;

endpackage

// File: rtl/vram_write_bridge_sync_fifo.sv
// sync_fifo: single-clock circular buffer with no handshake logic of its own.
// The caller must never push when full or pop when empty.
//   clk, rst (sync, active-low) : clock and reset (clears pointers and count)
//   push, push_data             : write push_data at the tail on this edge
//   pop                         : advance the head on this edge
//   pop_data                    : current head entry (combinational)
//   count                       : occupancy, one bit wider than the pointers
module sync_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; validity is tracked by the count alone.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;

endmodule

// File: rtl/vram_write_bridge.sv
// vram_write_bridge: buffers CPU bus writes and replays them onto the
// graphics card VRAM write port, one per cycle, optionally only while the
// display is blanked.
//   clk, rst (sync, active-low)
//   bus_write_valid/address/data, bus_write_ready : CPU write handshake
//   video_enable                                  : 1 = active scan-out
//   cpu_write_address/data, cpu_write_enable      : VRAM port, 1-cycle strobe
//   pending                                       : FIFO occupancy
//   busy                                          : FIFO non-empty or strobe high
module vram_write_bridge #(
  parameter int DEPTH      = 8,
  parameter bit BLANK_ONLY = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   bus_write_valid,
  input  logic [15:0]            bus_write_address,
  input  logic [7:0]             bus_write_data,
  output logic                   bus_write_ready,
  input  logic                   video_enable,
  output logic [15:0]            cpu_write_address,
  output logic [7:0]             cpu_write_data,
  output logic                   cpu_write_enable,
  output logic [$clog2(DEPTH):0] pending,
  output logic                   busy
);

  import gpu_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       count, count_next;
  vram_write_t            wr_entry, head;
  logic                   push, pop, blank_ok, drain_ok;
  logic                   wr_en_q, wr_en_d;
  logic [VRAM_ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [VRAM_DATA_W-1:0] wr_data_q, wr_data_d;

  // Ready looks only at the registered count so a full FIFO stays closed
  // even on a cycle that also pops.
  assign bus_write_ready = rst && (count < CNT_W'(DEPTH));
  assign push            = bus_write_valid && bus_write_ready;
  assign wr_entry        = '{addr: bus_write_address, data: bus_write_data};

  assign blank_ok   = !BLANK_ONLY || !video_enable;
  assign drain_ok   = (count != '0) && blank_ok;
  // IDLE always coincides with an empty FIFO, so this is drain_ok in practice.
  assign pop        = drain_ok && (state_q != IDLE);
  assign count_next = count + CNT_W'(push) - CNT_W'(pop);

  sync_fifo #(
    .WIDTH ($bits(vram_write_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (wr_entry),
    .pop       (pop),
    .pop_data  (head),
    .count     (count)
  );

  // Next state follows what the FIFO will hold after this edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (push) state_d = blank_ok ? ISSUE : WAIT_BLANK;
      end
      default: begin
        if (count_next == '0) state_d = IDLE;
        else if (blank_ok)    state_d = ISSUE;
        else                  state_d = WAIT_BLANK;
      end
    endcase
  end

  // Output stage: address/data hold between strobes.
  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (pop) begin
      wr_en_d   = 1'b1;
      wr_addr_d = head.addr;
      wr_data_d = head.data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign cpu_write_enable  = wr_en_q;
  assign cpu_write_address = wr_addr_q;
  assign cpu_write_data    = wr_data_q;
  assign pending           = count;
  assign busy              = (count != '0) || wr_en_q;

endmodule

// File: tb/tb_vram_write_bridge.sv
// tb_vram_write_bridge: directed table plus corner-case sequences against a
// BLANK_ONLY=1 instance, and a scoreboarded random run against BLANK_ONLY=0.
module tb_vram_write_bridge;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // BLANK_ONLY = 1 instance
  logic        b_valid = 1'b0, b_video = 1'b0;
  logic [15:0] b_addr = '0;
  logic [7:0]  b_data = '0;
  logic        b_ready, b_en, b_busy;
  logic [15:0] b_oaddr;
  logic [7:0]  b_odata;
  logic [3:0]  b_pend;

  // BLANK_ONLY = 0 instance
  logic        r_valid = 1'b0, r_video = 1'b0;
  logic [15:0] r_addr = '0;
  logic [7:0]  r_data = '0;
  logic        r_ready, r_en, r_busy;
  logic [15:0] r_oaddr;
  logic [7:0]  r_odata;
  logic [3:0]  r_pend;

  vram_write_bridge #(.DEPTH(8), .BLANK_ONLY(1'b1)) dut (
    .clk(clk), .rst(rst),
    .bus_write_valid(b_valid), .bus_write_address(b_addr), .bus_write_data(b_data),
    .bus_write_ready(b_ready), .video_enable(b_video),
    .cpu_write_address(b_oaddr), .cpu_write_data(b_odata), .cpu_write_enable(b_en),
    .pending(b_pend), .busy(b_busy)
  );

  vram_write_bridge #(.DEPTH(8), .BLANK_ONLY(1'b0)) dut0 (
    .clk(clk), .rst(rst),
    .bus_write_valid(r_valid), .bus_write_address(r_addr), .bus_write_data(r_data),
    .bus_write_ready(r_ready), .video_enable(r_video),
    .cpu_write_address(r_oaddr), .cpu_write_data(r_odata), .cpu_write_enable(r_en),
    .pending(r_pend), .busy(r_busy)
  );

  typedef struct packed {
    logic        valid;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        video;
    logic        ready;
    logic        en;
    logic [15:0] oaddr;
    logic [7:0]  odata;
    logic [3:0]  pend;
    logic        busy;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs [NVEC];

  int checks = 0;
  int errors = 0;
  logic [23:0] obs_q [$];
  logic [23:0] exp0_q [$];

  always @(negedge clk) begin
    if (b_en) obs_q.push_back({b_oaddr, b_odata});
  end

  function automatic vec_t mk(logic v, logic [15:0] a, logic [7:0] d, logic vid,
                              logic rdy, logic en, logic [15:0] oa, logic [7:0] od,
                              logic [3:0] p, logic bsy);
    vec_t t;
    t = '{valid: v, addr: a, data: d, video: vid, ready: rdy, en: en,
          oaddr: oa, odata: od, pend: p, busy: bsy};
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_order(input string nm, input int n, input int abase, input int dbase);
    logic [23:0] got;
    chk({nm, "_count"}, 32'(obs_q.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      got = '0;
      if (i < obs_q.size()) got = obs_q[i];
      chk($sformatf("%s_item%0d", nm, i), 32'(got), 32'({16'(abase + i), 8'(dbase + i)}));
    end
  endtask

  initial begin
    int          j;
    bit          acc;
    int          prev, mdl;
    logic [23:0] got;

    // Inputs for edge k, expected outputs after edge k
    vecs[0]  = mk(1, 16'h1234, 8'hAB, 0,  1, 0, 16'h0000, 8'h00, 4'd1, 1);
    vecs[1]  = mk(0, 16'h0000, 8'h00, 0,  1, 1, 16'h1234, 8'hAB, 4'd0, 1);
    vecs[2]  = mk(0, 16'h0000, 8'h00, 0,  1, 0, 16'h1234, 8'hAB, 4'd0, 0);
    vecs[3]  = mk(1, 16'h0001, 8'h11, 1,  1, 0, 16'h1234, 8'hAB, 4'd1, 1);
    vecs[4]  = mk(1, 16'h0002, 8'h22, 1,  1, 0, 16'h1234, 8'hAB, 4'd2, 1);
    vecs[5]  = mk(1, 16'h0003, 8'h33, 1,  1, 0, 16'h1234, 8'hAB, 4'd3, 1);
    vecs[6]  = mk(0, 16'h0000, 8'h00, 1,  1, 0, 16'h1234, 8'hAB, 4'd3, 1);
    vecs[7]  = mk(0, 16'h0000, 8'h00, 0,  1, 1, 16'h0001, 8'h11, 4'd2, 1);
    vecs[8]  = mk(0, 16'h0000, 8'h00, 0,  1, 1, 16'h0002, 8'h22, 4'd1, 1);
    vecs[9]  = mk(0, 16'h0000, 8'h00, 0,  1, 1, 16'h0003, 8'h33, 4'd0, 1);
    vecs[10] = mk(0, 16'h0000, 8'h00, 0,  1, 0, 16'h0003, 8'h33, 4'd0, 0);
    vecs[11] = mk(1, 16'hFFFF, 8'hFF, 0,  1, 0, 16'h0003, 8'h33, 4'd1, 1);
    vecs[12] = mk(1, 16'h00B0, 8'hB1, 0,  1, 1, 16'hFFFF, 8'hFF, 4'd1, 1);
    vecs[13] = mk(0, 16'h0000, 8'h00, 0,  1, 1, 16'h00B0, 8'hB1, 4'd0, 1);
    vecs[14] = mk(0, 16'h0000, 8'h00, 0,  1, 0, 16'h00B0, 8'hB1, 4'd0, 0);

    // Reset state
    repeat (2) cyc();
    chk("rst_ready", 32'(b_ready), 32'(0));
    chk("rst_en",    32'(b_en),    32'(0));
    chk("rst_addr",  32'(b_oaddr), 32'(0));
    chk("rst_data",  32'(b_odata), 32'(0));
    chk("rst_pend",  32'(b_pend),  32'(0));
    chk("rst_busy",  32'(b_busy),  32'(0));
    rst = 1'b1;

    // Directed table
    for (int i = 0; i < NVEC; i++) begin
      b_valid = vecs[i].valid;
      b_addr  = vecs[i].addr;
      b_data  = vecs[i].data;
      b_video = vecs[i].video;
      cyc();
      chk($sformatf("vec%0d_ready", i), 32'(b_ready), 32'(vecs[i].ready));
      chk($sformatf("vec%0d_en", i),    32'(b_en),    32'(vecs[i].en));
      chk($sformatf("vec%0d_addr", i),  32'(b_oaddr), 32'(vecs[i].oaddr));
      chk($sformatf("vec%0d_data", i),  32'(b_odata), 32'(vecs[i].odata));
      chk($sformatf("vec%0d_pend", i),  32'(b_pend),  32'(vecs[i].pend));
      chk($sformatf("vec%0d_busy", i),  32'(b_busy),  32'(vecs[i].busy));
    end
    b_valid = 1'b0;

    // Overfill during active video: 9 writes offered, 8 fit, held 20 cycles
    obs_q.delete();
    b_video = 1'b1;
    j = 0;
    for (int c = 0; c < 20; c++) begin
      b_valid = (j < 9);
      b_addr  = 16'(256 + j);
      b_data  = 8'(80 + j);
      acc = b_valid && b_ready;
      cyc();
      if (acc) j++;
    end
    chk("full_accepted", 32'(j),             32'(8));
    chk("full_ready",    32'(b_ready),       32'(0));
    chk("full_pend",     32'(b_pend),        32'(8));
    chk("full_nostrobe", 32'(obs_q.size()),  32'(0));

    // Blanking starts: first pop frees a slot, stalled write gets in next
    b_video = 1'b0;
    acc = b_valid && b_ready;
    cyc();
    if (acc) j++;
    chk("full_pop1_pend",  32'(b_pend),  32'(7));
    chk("full_pop1_ready", 32'(b_ready), 32'(1));
    chk("full_pop1_en",    32'(b_en),    32'(1));
    for (int c = 0; c < 15; c++) begin
      b_valid = (j < 9);
      b_addr  = 16'(256 + j);
      b_data  = 8'(80 + j);
      acc = b_valid && b_ready;
      cyc();
      if (acc) j++;
    end
    b_valid = 1'b0;
    check_order("full", 9, 256, 80);
    chk("full_end_pend", 32'(b_pend), 32'(0));
    chk("full_end_busy", 32'(b_busy), 32'(0));

    // Drain paused by video_enable rising part-way through
    obs_q.delete();
    b_video = 1'b1;
    for (int i = 0; i < 5; i++) begin
      b_valid = 1'b1;
      b_addr  = 16'(512 + i);
      b_data  = 8'(96 + i);
      cyc();
    end
    b_valid = 1'b0;
    chk("pause_pend5", 32'(b_pend), 32'(5));
    b_video = 1'b0;
    cyc();
    cyc();
    chk("pause_pend3", 32'(b_pend), 32'(3));
    chk("pause_en_before", 32'(b_en), 32'(1));
    b_video = 1'b1;
    cyc();
    chk("pause_en_after", 32'(b_en),   32'(0));
    chk("pause_pend_hold", 32'(b_pend), 32'(3));
    repeat (10) cyc();
    chk("pause_obs2",  32'(obs_q.size()), 32'(2));
    chk("pause_busy",  32'(b_busy),       32'(1));
    b_video = 1'b0;
    repeat (6) cyc();
    check_order("pause", 5, 512, 96);

    // Reset with entries pending
    obs_q.delete();
    b_video = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b_valid = 1'b1;
      b_addr  = 16'(768 + i);
      b_data  = 8'(112 + i);
      cyc();
    end
    b_valid = 1'b0;
    chk("mrst_pend4", 32'(b_pend), 32'(4));
    rst = 1'b0;
    b_video = 1'b0;
    #1;
    chk("mrst_ready_low", 32'(b_ready), 32'(0));
    cyc();
    chk("mrst_pend", 32'(b_pend),  32'(0));
    chk("mrst_en",   32'(b_en),    32'(0));
    chk("mrst_busy", 32'(b_busy),  32'(0));
    chk("mrst_addr", 32'(b_oaddr), 32'(0));
    cyc();
    chk("mrst_obs_in", 32'(obs_q.size()), 32'(0));
    rst = 1'b1;
    #1;
    chk("mrst_ready_high", 32'(b_ready), 32'(1));
    repeat (5) cyc();
    chk("mrst_obs_after", 32'(obs_q.size()), 32'(0));
    chk("mrst_pend_after", 32'(b_pend), 32'(0));

    // BLANK_ONLY = 0: random traffic against a scoreboard
    mdl = 0;
    for (int c = 0; c < 400; c++) begin
      r_valid = (c < 370) && ($urandom_range(0, 3) != 0);
      r_addr  = 16'($urandom);
      r_data  = 8'($urandom);
      r_video = 1'($urandom);
      prev = mdl;
      acc  = r_valid && r_ready;
      if (acc) exp0_q.push_back({r_addr, r_data});
      cyc();
      chk("rand_strobe", 32'(r_en), 32'(prev != 0));
      if (r_en) begin
        got = '0;
        if (exp0_q.size() > 0) got = exp0_q.pop_front();
        chk("rand_item", 32'({r_oaddr, r_odata}), 32'(got));
      end
      mdl = prev + int'(acc) - int'(prev != 0);
      chk("rand_pend", 32'(r_pend), 32'(mdl));
      chk("rand_busy", 32'(r_busy), 32'((mdl != 0) || (prev != 0)));
    end
    r_valid = 1'b0;
    chk("rand_left", 32'(exp0_q.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
